// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: instruction field
// encodings, ALU operation codes, mux select encodings and the FSM state type.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 4;

    // OpCode field values
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // Func field values for R-type
    localparam logic [OP_W-1:0] FN_SLL = 6'b000000;
    localparam logic [OP_W-1:0] FN_SRL = 6'b000010;
    localparam logic [OP_W-1:0] FN_JR  = 6'b001000;
    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_XOR = 6'b100110;
    localparam logic [OP_W-1:0] FN_NOR = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
    localparam logic [OP_W-1:0] FN_SGT = 6'b101011;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
        ALU_NOR = 4'b0100, ALU_XOR = 4'b0101, ALU_SLT = 4'b0110, ALU_SGT = 4'b0111,
        ALU_SLL = 4'b1000, ALU_SRL = 4'b1001, ALU_BEQ = 4'b1010, ALU_BNE = 4'b1011,
        ALU_NOP = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RS = 2'b11
    } pc_src_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEMADR, S_MEMRD,
        S_MEMWR, S_MEM_WB, S_BRANCH, S_JUMP, S_JR, S_JAL, S_ILLEGAL
    } state_e;

    // States that issue a memory request and may stall on mem_ready
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// ALU operation decode for arithmetic/logic/shift instructions.
// Ports:
//   opcode_i  IR[31:26]
//   func_i    IR[5:0]
//   alu_op_o  ALU operation code (NOP when not an ALU instruction)
//   legal_o   1 when opcode/func is a supported R-type or I-type ALU instruction
module mc_alu_op_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0]    opcode_i,
    input  logic [OP_W-1:0]    func_i,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               legal_o
);

    always_comb begin
        alu_op_o = ALU_NOP;
        legal_o  = 1'b1;
        if (opcode_i == OP_RTYPE) begin
            case (func_i)
                FN_ADD:  alu_op_o = ALU_ADD;
                FN_SUB:  alu_op_o = ALU_SUB;
                FN_AND:  alu_op_o = ALU_AND;
                FN_OR:   alu_op_o = ALU_OR;
                FN_NOR:  alu_op_o = ALU_NOR;
                FN_XOR:  alu_op_o = ALU_XOR;
                FN_SLT:  alu_op_o = ALU_SLT;
                FN_SGT:  alu_op_o = ALU_SGT;
                FN_SLL:  alu_op_o = ALU_SLL;
                FN_SRL:  alu_op_o = ALU_SRL;
                default: legal_o  = 1'b0;
            endcase
        end else begin
            case (opcode_i)
                OP_ADDI: alu_op_o = ALU_ADD;
                OP_ANDI: alu_op_o = ALU_AND;
                OP_ORI:  alu_op_o = ALU_OR;
                OP_XORI: alu_op_o = ALU_XOR;
                OP_SLTI: alu_op_o = ALU_SLT;
                default: legal_o  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: steps each instruction through FETCH/DECODE/
// EXEC/MEM/WB and drives the datapath strobes for the shared ALU, register
// file and unified memory, stalling memory states on mem_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   OpCode, Func, Zero  instruction fields and ALU equality flag
//   mem_ready           memory completes the current request this cycle
//   PCEn..PCSource      datapath strobes and mux selects
//   instr_done          pulse in the final cycle of each instruction
//   illegal_instr       pulse on an unknown OpCode/Func
//   mem_timeout         pulse when a memory wait exceeds MEM_TIMEOUT
//   cycle_cnt/instr_cnt performance counters, present only with MC_PERF_CNT_EN
// Configuration macro: MC_PERF_CNT_EN adds the performance counters.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
`ifdef MC_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    OpCode,
    input  logic [OP_W-1:0]    Func,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCEn,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               JAL,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [ALUOP_W-1:0] AluOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal_instr,
    output logic               mem_timeout
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
`endif
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ALUOP_W-1:0]  dec_alu_op;
    logic                dec_legal;
    logic                timeout_hit;

    mc_alu_op_decode u_alu_op_decode (
        .opcode_i (OpCode),
        .func_i   (Func),
        .alu_op_o (dec_alu_op),
        .legal_o  (dec_legal)
    );

    // Wait limit reached in a memory state; only possible when a limit is set
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));

    // Next state and output decode; everything is held idle while rst is high
    always_comb begin
        state_d       = state_q;
        PCEn          = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        JAL           = 1'b0;
        AluSrcA       = 1'b0;
        AluSrcB       = SRCB_RT;
        AluOp         = ALU_NOP;
        PCSource      = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    AluSrcB = SRCB_FOUR;
                    AluOp   = ALU_ADD;
                    // Timeout drops the request; staying in FETCH re-reads the same PC
                    if (timeout_hit) begin
                        MemRead     = 1'b0;
                        mem_timeout = 1'b1;
                    end else if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCEn    = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    AluSrcB = SRCB_IMM_SH2;
                    AluOp   = ALU_ADD;
                    if ((OpCode == OP_RTYPE) && (Func == FN_JR)) begin
                        state_d = S_JR;
                    end else if (dec_legal) begin
                        state_d = (OpCode == OP_RTYPE) ? S_EXEC_R : S_EXEC_I;
                    end else begin
                        case (OpCode)
                            OP_LW, OP_SW:   state_d = S_MEMADR;
                            OP_BEQ, OP_BNE: state_d = S_BRANCH;
                            OP_J:           state_d = S_JUMP;
                            OP_JAL:         state_d = S_JAL;
                            default:        state_d = S_ILLEGAL;
                        endcase
                    end
                end
                S_EXEC_R, S_EXEC_I: begin
                    AluSrcA = 1'b1;
                    AluSrcB = (state_q == S_EXEC_R) ? SRCB_RT : SRCB_IMM;
                    AluOp   = dec_alu_op;
                    state_d = S_ALU_WB;
                end
                S_ALU_WB: begin
                    RegDst     = (OpCode == OP_RTYPE);
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMADR: begin
                    AluSrcA = 1'b1;
                    AluSrcB = SRCB_IMM;
                    AluOp   = ALU_ADD;
                    state_d = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    if (timeout_hit) begin
                        MemRead     = 1'b0;
                        mem_timeout = 1'b1;
                        state_d     = S_FETCH;
                    end else if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    if (timeout_hit) begin
                        MemWrite    = 1'b0;
                        mem_timeout = 1'b1;
                        state_d     = S_FETCH;
                    end else if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_MEM_WB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    AluSrcA    = 1'b1;
                    AluSrcB    = SRCB_RT;
                    AluOp      = (OpCode == OP_BNE) ? ALU_BNE : ALU_BEQ;
                    PCSource   = PCSRC_ALUOUT;
                    PCEn       = Zero ^ (OpCode == OP_BNE);
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JUMP, S_JR: begin
                    PCSource   = (state_q == S_JR) ? PCSRC_RS : PCSRC_JUMP;
                    PCEn       = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JAL: begin
                    PCSource   = PCSRC_JUMP;
                    PCEn       = 1'b1;
                    RegWrite   = 1'b1;
                    JAL        = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal_instr = 1'b1;
                    instr_done    = 1'b1;
                    state_d       = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end

        // Wait counter: clears on any state change or timeout, saturates at the limit
        wait_d = wait_q;
        if ((state_d != state_q) || timeout_hit) begin
            wait_d = '0;
        end else if (is_mem_state(state_q) && !mem_ready && (wait_q != WAIT_W'(MEM_TIMEOUT))) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef MC_PERF_CNT_EN
    // Free-running cycle and retired-instruction counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            instr_cnt <= instr_cnt + CNT_W'(instr_done);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Two instances share all
// inputs: dut0 waits forever on memory, dut1 has a wait limit of 4.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jal;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_instr;
        logic       mem_timeout;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       zero;
        out_t       exp;
    } cyc_t;

    localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_BNE = 5, K_J = 6, K_JR = 7, K_JAL = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] OpCode = '0;
    logic [5:0] Func = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    out_t       obs0, obs1;
    int         n_checks = 0;
    int         n_fail = 0;
    cyc_t       script[$];
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt0, ins_cnt0, cyc_cnt1, ins_cnt1;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .Zero(Zero), .mem_ready(mem_ready),
        .PCEn(obs0.pc_en), .IorD(obs0.iord), .IRWrite(obs0.ir_write), .MemRead(obs0.mem_read),
        .MemWrite(obs0.mem_write), .MemtoReg(obs0.mem_to_reg), .RegDst(obs0.reg_dst),
        .RegWrite(obs0.reg_write), .JAL(obs0.jal), .AluSrcA(obs0.alu_src_a),
        .AluSrcB(obs0.alu_src_b), .AluOp(obs0.alu_op), .PCSource(obs0.pc_source),
        .instr_done(obs0.instr_done), .illegal_instr(obs0.illegal_instr),
        .mem_timeout(obs0.mem_timeout)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cyc_cnt0), .instr_cnt(ins_cnt0)
`endif
    );

    multicycle_controller #(.MEM_TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .Zero(Zero), .mem_ready(mem_ready),
        .PCEn(obs1.pc_en), .IorD(obs1.iord), .IRWrite(obs1.ir_write), .MemRead(obs1.mem_read),
        .MemWrite(obs1.mem_write), .MemtoReg(obs1.mem_to_reg), .RegDst(obs1.reg_dst),
        .RegWrite(obs1.reg_write), .JAL(obs1.jal), .AluSrcA(obs1.alu_src_a),
        .AluSrcB(obs1.alu_src_b), .AluOp(obs1.alu_op), .PCSource(obs1.pc_source),
        .instr_done(obs1.instr_done), .illegal_instr(obs1.illegal_instr),
        .mem_timeout(obs1.mem_timeout)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cyc_cnt1), .instr_cnt(ins_cnt1)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int ref_kind(input logic [5:0] op, input logic [5:0] fn);
        int k;
        k = K_ILL;
        case (op)
            6'h00: begin
                if (fn == 6'h08) k = K_JR;
                else if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26,
                                    6'h2a, 6'h2b, 6'h00, 6'h02}) k = K_RALU;
            end
            6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a: k = K_IALU;
            6'h23: k = K_LW;
            6'h2b: k = K_SW;
            6'h04: k = K_BEQ;
            6'h05: k = K_BNE;
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] key;
        logic [3:0] a;
        a = 4'hF;
        key = (op == 6'h00) ? fn : op;
        if (op == 6'h00) begin
            case (key)
                6'h20: a = 4'h0; 6'h22: a = 4'h1; 6'h24: a = 4'h2; 6'h25: a = 4'h3;
                6'h27: a = 4'h4; 6'h26: a = 4'h5; 6'h2a: a = 4'h6; 6'h2b: a = 4'h7;
                6'h00: a = 4'h8; 6'h02: a = 4'h9; default: a = 4'hF;
            endcase
        end else begin
            case (key)
                6'h08: a = 4'h0; 6'h0c: a = 4'h2; 6'h0d: a = 4'h3;
                6'h0e: a = 4'h5; 6'h0a: a = 4'h6; default: a = 4'hF;
            endcase
        end
        return a;
    endfunction

    function automatic out_t o_idle();
        out_t o;
        o = '0;
        o.alu_op = 4'hF;
        return o;
    endfunction

    function automatic out_t o_fetch();
        out_t o;
        o = o_idle();
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.alu_op    = 4'h0;
        return o;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic zero, input out_t e);
        cyc_t c;
        c.op = op; c.fn = fn; c.rdy = rdy; c.zero = zero; c.exp = e;
        script.push_back(c);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from its class
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        out_t o;
        int   k;
        k = ref_kind(op, fn);
        o = o_fetch();
        for (int i = 0; i < fw; i++) push(op, fn, 1'b0, rnd1(), o);
        o.ir_write = 1'b1; o.pc_en = 1'b1;
        push(op, fn, 1'b1, rnd1(), o);
        o = o_idle(); o.alu_src_b = 2'b11; o.alu_op = 4'h0;
        push(op, fn, rnd1(), rnd1(), o);
        o = o_idle();
        case (k)
            K_RALU, K_IALU: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = (k == K_RALU) ? 2'b00 : 2'b10;
                o.alu_op    = ref_alu(op, fn);
                push(op, fn, rnd1(), rnd1(), o);
                o = o_idle();
                o.reg_dst = (k == K_RALU); o.reg_write = 1'b1; o.instr_done = 1'b1;
                push(op, fn, rnd1(), rnd1(), o);
            end
            K_LW, K_SW: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 4'h0;
                push(op, fn, rnd1(), rnd1(), o);
                o = o_idle(); o.iord = 1'b1;
                if (k == K_LW) o.mem_read = 1'b1; else o.mem_write = 1'b1;
                for (int i = 0; i < mw; i++) push(op, fn, 1'b0, rnd1(), o);
                if (k == K_SW) o.instr_done = 1'b1;
                push(op, fn, 1'b1, rnd1(), o);
                if (k == K_LW) begin
                    o = o_idle();
                    o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
                    push(op, fn, rnd1(), rnd1(), o);
                end
            end
            K_BEQ, K_BNE: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b00;
                o.alu_op    = (k == K_BNE) ? 4'hB : 4'hA;
                o.pc_source = 2'b01;
                o.pc_en     = (k == K_BNE) ? ~z : z;
                o.instr_done = 1'b1;
                push(op, fn, rnd1(), z, o);
            end
            K_J, K_JR: begin
                o.pc_source = (k == K_JR) ? 2'b11 : 2'b10;
                o.pc_en = 1'b1; o.instr_done = 1'b1;
                push(op, fn, rnd1(), rnd1(), o);
            end
            K_JAL: begin
                o.pc_source = 2'b10; o.pc_en = 1'b1; o.reg_write = 1'b1;
                o.jal = 1'b1; o.instr_done = 1'b1;
                push(op, fn, rnd1(), rnd1(), o);
            end
            default: begin
                o.illegal_instr = 1'b1; o.instr_done = 1'b1;
                push(op, fn, rnd1(), rnd1(), o);
            end
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (obs0 !== o_idle()) begin
                n_fail++; $display("FAIL reset dut0 cyc %0d: got %h want %h", i, obs0, o_idle());
            end
            if (obs1 !== o_idle()) begin
                n_fail++; $display("FAIL reset dut1 cyc %0d: got %h want %h", i, obs1, o_idle());
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_instructions();
        logic [5:0] ops[12];
        logic [5:0] fns[11];
        logic [5:0] op, fn;
        cyc_t       c;
        int         cyc;
        ops = '{6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h08};
        // Directed cases: ADD, LW with 3 waits, BEQ/BNE both Zero values, illegal ops, jumps, SW
        add_instr(6'h00, 6'h20, 1'b0, 0, 0);
        add_instr(6'h23, 6'h00, 1'b0, 0, 3);
        add_instr(6'h04, 6'h00, 1'b1, 0, 0);
        add_instr(6'h04, 6'h00, 1'b0, 0, 0);
        add_instr(6'h05, 6'h00, 1'b1, 0, 0);
        add_instr(6'h05, 6'h00, 1'b0, 0, 0);
        add_instr(6'h3f, 6'h00, 1'b0, 0, 0);
        add_instr(6'h00, 6'h3f, 1'b0, 1, 0);
        add_instr(6'h00, 6'h08, 1'b0, 0, 0);
        add_instr(6'h03, 6'h00, 1'b0, 2, 0);
        add_instr(6'h2b, 6'h00, 1'b0, 0, 2);
        add_instr(6'h0e, 6'h00, 1'b0, 3, 0);
        // Random mix, including arbitrary encodings
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: begin op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
                1, 2: begin op = 6'h00; fn = fns[$urandom_range(0, 10)]; end
                default: begin
                    op = (n % 7 == 0) ? 6'h03 : ops[$urandom_range(2, 11)];
                    fn = 6'($urandom_range(0, 63));
                end
            endcase
            add_instr(op, fn, rnd1(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        cyc = 0;
        while (script.size() > 0) begin
            c = script.pop_front();
            OpCode = c.op; Func = c.fn; mem_ready = c.rdy; Zero = c.zero;
            @(negedge clk);
            n_checks += 2;
            if (obs0 !== c.exp) begin
                n_fail++;
                $display("FAIL instr dut0 cyc %0d op=%h fn=%h: got %h want %h", cyc, c.op, c.fn, obs0, c.exp);
            end
            if (obs1 !== c.exp) begin
                n_fail++;
                $display("FAIL instr dut1 cyc %0d op=%h fn=%h: got %h want %h", cyc, c.op, c.fn, obs1, c.exp);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    // Fetch stall: dut1 drops the request every 5th cycle, dut0 waits on.
    // Then a load stalls in MEMRD: dut1 times out and returns to FETCH.
    task automatic test_timeout();
        out_t e0, e1;
        OpCode = 6'h23; Func = 6'h00; Zero = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            mem_ready = (k == 11) ? 1'b1 : 1'b0;
            e0 = o_idle(); e1 = o_idle();
            if (k <= 10) begin
                e0 = o_fetch(); e1 = o_fetch();
                if (k % 5 == 0) begin e1.mem_read = 1'b0; e1.mem_timeout = 1'b1; end
            end else if (k == 11) begin
                e0 = o_fetch(); e0.ir_write = 1'b1; e0.pc_en = 1'b1; e1 = e0;
            end else if (k == 12) begin
                e0.alu_src_b = 2'b11; e0.alu_op = 4'h0; e1 = e0;
            end else if (k == 13) begin
                e0.alu_src_a = 1'b1; e0.alu_src_b = 2'b10; e0.alu_op = 4'h0; e1 = e0;
            end else begin
                e0.iord = 1'b1; e0.mem_read = 1'b1; e1 = e0;
                if (k == 18) begin e1.mem_read = 1'b0; e1.mem_timeout = 1'b1; end
                else if (k > 18) e1 = o_fetch();
            end
            @(negedge clk);
            n_checks += 2;
            if (obs0 !== e0) begin
                n_fail++; $display("FAIL timeout dut0 cyc %0d: got %h want %h", k, obs0, e0);
            end
            if (obs1 !== e1) begin
                n_fail++; $display("FAIL timeout dut1 cyc %0d: got %h want %h", k, obs1, e1);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset while the two instances sit in different states, then a J restarts cleanly
    task automatic test_reset_abort();
        out_t e;
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (obs0 !== o_idle()) begin
            n_fail++; $display("FAIL abort dut0: got %h want %h", obs0, o_idle());
        end
        if (obs1 !== o_idle()) begin
            n_fail++; $display("FAIL abort dut1: got %h want %h", obs1, o_idle());
        end
        @(posedge clk); #1;
        rst = 1'b0; OpCode = 6'h02; Func = 6'h00;
        for (int k = 0; k < 3; k++) begin
            e = o_idle();
            if (k == 0) begin e = o_fetch(); e.ir_write = 1'b1; e.pc_en = 1'b1; end
            else if (k == 1) begin e.alu_src_b = 2'b11; e.alu_op = 4'h0; end
            else begin e.pc_source = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1; end
            @(negedge clk);
            n_checks += 2;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL restart dut0 cyc %0d: got %h want %h", k, obs0, e);
            end
            if (obs1 !== e) begin
                n_fail++; $display("FAIL restart dut1 cyc %0d: got %h want %h", k, obs1, e);
            end
            @(posedge clk); #1;
        end
`ifdef MC_PERF_CNT_EN
        n_checks += 4;
        if (cyc_cnt0 !== 32'd3) begin n_fail++; $display("FAIL cycle_cnt dut0: got %0d want 3", cyc_cnt0); end
        if (cyc_cnt1 !== 32'd3) begin n_fail++; $display("FAIL cycle_cnt dut1: got %0d want 3", cyc_cnt1); end
        if (ins_cnt0 !== 32'd1) begin n_fail++; $display("FAIL instr_cnt dut0: got %0d want 1", ins_cnt0); end
        if (ins_cnt1 !== 32'd1) begin n_fail++; $display("FAIL instr_cnt dut1: got %0d want 1", ins_cnt1); end
`endif
    endtask

    initial begin
        test_reset();
        test_instructions();
        test_timeout();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
